riscv_dmem_mmio: RTL and testbench

Data-side memory subsystem directly downstream of the RV32I single-cycle CPU's data memory port. Word-organised RAM with per-byte write enables, plus a small memory-mapped peripheral region: a GPIO output register and a 64-bit machine timer with compare interrupt. Reads are combinational so the single-cycle core gets load data in the same cycle. Writes and all timer state are sequential.

---
 rtl/riscv_dmem_mmio.sv | 138 +++++++++++++
 tb/tb_riscv_dmem_mmio.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_mmio.sv
// riscv_dmem_mmio: data-side memory for the single-cycle RV32I core.
// Word RAM with byte-lane writes plus an MMIO page at 0x1000_0000 holding a
// GPIO output register and a 64-bit machine timer with compare interrupt.
// Ports:
//   i_clk, i_rstn       clock, asynchronous active-low reset
//   i_dmem_addr         byte address (bits [1:0] ignored)
//   i_dmem_wr_en        store strobe
//   i_dmem_wr_data      lane-aligned store data
//   i_dmem_byte_sel     per-lane write enables
//   o_dmem_rd_data      combinational load data for the addressed word
//   o_gpio_out          GPIO output register
//   o_timer_irq         registered level timer interrupt
module riscv_dmem_mmio #(
   parameter int unsigned DMEM_DEPTH = 1024,
   parameter int unsigned TIMER_DIV  = 1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_wr_en,
   input  logic [31:0] i_dmem_wr_data,
   input  logic [3:0]  i_dmem_byte_sel,
   output logic [31:0] o_dmem_rd_data,
   output logic [31:0] o_gpio_out,
   output logic        o_timer_irq
);

   localparam int unsigned AW = $clog2(DMEM_DEPTH);
   localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   // 0x1000_0000 >> 5: the MMIO page covers offsets 0x00..0x1F
   localparam logic [26:0] MMIO_PAGE = 27'h080_0000;

   localparam logic [2:0] OFF_GPIO  = 3'd0;
   localparam logic [2:0] OFF_MTLO  = 3'd2;
   localparam logic [2:0] OFF_MTHI  = 3'd3;
   localparam logic [2:0] OFF_CMPLO = 3'd4;
   localparam logic [2:0] OFF_CMPHI = 3'd5;
   localparam logic [2:0] OFF_CTRL  = 3'd6;

   // Replace the selected byte lanes of a word with store data
   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0]  sel);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) r[8*i +: 8] = wd[8*i +: 8];
      end
      return r;
   endfunction

   logic [31:0]   mem [DMEM_DEPTH];
   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic [1:0]    ctrl;        // [0] EN, [1] IRQ_EN
   logic [PW-1:0] presc;

   logic          ram_hit;
   logic          mmio_hit;
   logic [2:0]    off;
   logic [AW-1:0] ram_idx;
   logic          wr_gpio, wr_mtlo, wr_mthi, wr_cmplo, wr_cmphi, wr_ctrl;
   logic          tick;
   logic          unused_addr_bits;

   // Address decode on the word address
   assign ram_hit  = (i_dmem_addr[31:AW+2] == '0);
   assign mmio_hit = (i_dmem_addr[31:5] == MMIO_PAGE);
   assign off      = i_dmem_addr[4:2];
   assign ram_idx  = i_dmem_addr[AW+1:2];
   assign unused_addr_bits = ^i_dmem_addr[1:0];

   assign wr_gpio  = i_dmem_wr_en && mmio_hit && (off == OFF_GPIO);
   assign wr_mtlo  = i_dmem_wr_en && mmio_hit && (off == OFF_MTLO);
   assign wr_mthi  = i_dmem_wr_en && mmio_hit && (off == OFF_MTHI);
   assign wr_cmplo = i_dmem_wr_en && mmio_hit && (off == OFF_CMPLO);
   assign wr_cmphi = i_dmem_wr_en && mmio_hit && (off == OFF_CMPHI);
   assign wr_ctrl  = i_dmem_wr_en && mmio_hit && (off == OFF_CTRL);

   assign tick = ctrl[0] && (presc == PW'(TIMER_DIV - 1));

   // RAM store path; contents are intentionally not reset
   always_ff @(posedge i_clk) begin
      if (i_dmem_wr_en && ram_hit) begin
         mem[ram_idx] <= merge(mem[ram_idx], i_dmem_wr_data, i_dmem_byte_sel);
      end
   end

   // MMIO registers, prescaler, timer and interrupt
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_gpio_out  <= '0;
         mtime       <= '0;
         mtimecmp    <= '1;
         ctrl        <= '0;
         presc       <= '0;
         o_timer_irq <= 1'b0;
      end else begin
         if (wr_gpio)  o_gpio_out      <= merge(o_gpio_out, i_dmem_wr_data, i_dmem_byte_sel);
         if (wr_cmplo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], i_dmem_wr_data, i_dmem_byte_sel);
         if (wr_cmphi) mtimecmp[63:32] <= merge(mtimecmp[63:32], i_dmem_wr_data, i_dmem_byte_sel);
         if (wr_ctrl && i_dmem_byte_sel[0]) ctrl <= i_dmem_wr_data[1:0];

         if (!ctrl[0] || tick) presc <= '0;
         else                  presc <= presc + PW'(1);

         // A CPU write to either half wins over a coincident tick
         if (wr_mtlo || wr_mthi) begin
            if (wr_mtlo) mtime[31:0]  <= merge(mtime[31:0], i_dmem_wr_data, i_dmem_byte_sel);
            if (wr_mthi) mtime[63:32] <= merge(mtime[63:32], i_dmem_wr_data, i_dmem_byte_sel);
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         o_timer_irq <= ctrl[1] && (mtime >= mtimecmp);
      end
   end

   // Combinational load data; unmapped addresses read zero
   always_comb begin
      o_dmem_rd_data = '0;
      if (ram_hit) begin
         o_dmem_rd_data = mem[ram_idx];
      end else if (mmio_hit) begin
         case (off)
            OFF_GPIO:  o_dmem_rd_data = o_gpio_out;
            OFF_MTLO:  o_dmem_rd_data = mtime[31:0];
            OFF_MTHI:  o_dmem_rd_data = mtime[63:32];
            OFF_CMPLO: o_dmem_rd_data = mtimecmp[31:0];
            OFF_CMPHI: o_dmem_rd_data = mtimecmp[63:32];
            OFF_CTRL:  o_dmem_rd_data = {30'd0, ctrl};
            default:   o_dmem_rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Scoreboard bench for riscv_dmem_mmio: two instances (TIMER_DIV=4 and 1)
// share the CPU-side stimulus; each check names the instance it observes.
module tb_riscv_dmem_mmio;

   localparam logic [31:0] A_GPIO  = 32'h1000_0000;
   localparam logic [31:0] A_MTLO  = 32'h1000_0008;
   localparam logic [31:0] A_MTHI  = 32'h1000_000C;
   localparam logic [31:0] A_CMPLO = 32'h1000_0010;
   localparam logic [31:0] A_CMPHI = 32'h1000_0014;
   localparam logic [31:0] A_CTRL  = 32'h1000_0018;

   localparam int K_RD   = 0;
   localparam int K_GPIO = 1;
   localparam int K_IRQ  = 2;

   typedef struct {
      logic [31:0] exp;
      int          kind;
      bit          dut;
      string       name;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [3:0]  byte_sel;
   logic [31:0] rd4, rd1, gpio4, gpio1;
   logic        irq4, irq1;

   bit   sel_dut;
   bit   chk_req;
   bit   final_chk;
   exp_t q[$];
   int   n_vec;
   int   n_err;

   riscv_dmem_mmio #(.DMEM_DEPTH(1024), .TIMER_DIV(4)) u_div4 (
      .i_clk(clk), .i_rstn(rstn), .i_dmem_addr(addr), .i_dmem_wr_en(wr_en),
      .i_dmem_wr_data(wr_data), .i_dmem_byte_sel(byte_sel),
      .o_dmem_rd_data(rd4), .o_gpio_out(gpio4), .o_timer_irq(irq4));

   riscv_dmem_mmio #(.DMEM_DEPTH(1024), .TIMER_DIV(1)) u_div1 (
      .i_clk(clk), .i_rstn(rstn), .i_dmem_addr(addr), .i_dmem_wr_en(wr_en),
      .i_dmem_wr_data(wr_data), .i_dmem_byte_sel(byte_sel),
      .o_dmem_rd_data(rd1), .o_gpio_out(gpio1), .o_timer_irq(irq1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops an expectation whenever a check is presented
   always @(negedge clk) begin
      exp_t        t;
      logic [31:0] act;
      if (chk_req) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_underflow: no expected value queued");
         end else begin
            t = q.pop_front();
            case (t.kind)
               K_RD:    act = t.dut ? rd1 : rd4;
               K_GPIO:  act = t.dut ? gpio1 : gpio4;
               default: act = {31'd0, (t.dut ? irq1 : irq4)};
            endcase
            if (act !== t.exp) begin
               n_err++;
               $display("FAIL %s: got %08h expected %08h", t.name, act, t.exp);
            end
         end
      end
      if (final_chk) begin
         n_vec++;
         if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", q.size());
         end
      end
   end

   task automatic push(input int kind, input logic [31:0] e, input string nm);
      exp_t t;
      t.exp  = e;
      t.kind = kind;
      t.dut  = sel_dut;
      t.name = nm;
      q.push_back(t);
   endtask

   // One bus cycle: inputs change 1 time unit after the rising edge
   task automatic apply(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] s, input bit chk, input int kind,
                        input logic [31:0] e, input string nm);
      @(posedge clk);
      #1;
      addr = a; wr_en = we; wr_data = d; byte_sel = s;
      if (chk) push(kind, e, nm);
      chk_req = chk;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      apply(a, 1'b1, d, s, 1'b0, K_RD, 32'd0, "");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      apply(a, 1'b0, 32'd0, 4'd0, 1'b1, K_RD, e, nm);
   endtask

   task automatic chk_gpio(input logic [31:0] e, input string nm);
      apply(32'd0, 1'b0, 32'd0, 4'd0, 1'b1, K_GPIO, e, nm);
   endtask

   task automatic chk_irq(input logic e, input string nm);
      apply(32'd0, 1'b0, 32'd0, 4'd0, 1'b1, K_IRQ, {31'd0, e}, nm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(32'd0, 1'b0, 32'd0, 4'd0, 1'b0, K_RD, 32'd0, "");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0; addr = '0; wr_en = 1'b0; wr_data = '0; byte_sel = '0;
      sel_dut = 1'b0; chk_req = 1'b0; final_chk = 1'b0;
      n_vec = 0; n_err = 0;

      // Reset state
      idle(1);
      chk_gpio(32'h0, "rst_gpio");
      chk_irq(1'b0, "rst_irq");
      rd(A_MTLO,  32'h0, "rst_mtime_lo");
      rd(A_MTHI,  32'h0, "rst_mtime_hi");
      rd(A_CMPLO, 32'hFFFF_FFFF, "rst_cmp_lo");
      rd(A_CMPHI, 32'hFFFF_FFFF, "rst_cmp_hi");
      rd(A_CTRL,  32'h0, "rst_ctrl");
      @(posedge clk); #1; rstn = 1'b1; chk_req = 1'b0;

      // Byte-lane write and ignored low address bits
      wr(32'h10, 32'hAABB_CCDD, 4'b1111);
      wr(32'h10, 32'h0000_EE00, 4'b0010);
      rd(32'h10, 32'hAABB_EEDD, "lane_merge");
      rd(32'h13, 32'hAABB_EEDD, "lane_addr13");
      wr(32'h14, 32'h5555_5555, 4'b0000);
      rd(32'h14 - 32'h4, 32'hAABB_EEDD, "sel0_noop_neighbour");

      // Unmapped addresses and aliasing
      wr(32'h0, 32'h1122_3344, 4'b1111);
      wr(32'h2000_0000, 32'h1234_5678, 4'b1111);
      rd(32'h2000_0000, 32'h0, "unmapped_read");
      rd(32'h0, 32'h1122_3344, "ram0_unchanged");
      chk_gpio(32'h0, "gpio_unchanged");
      wr(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
      rd(32'h0000_1000, 32'h0, "beyond_ram_read");
      rd(32'h0, 32'h1122_3344, "no_alias_ram0");
      rd(32'h1000_0004, 32'h0, "mmio_hole_read");
      apply(A_GPIO, 1'b1, 32'h0000_00FF, 4'b0001, 1'b1, K_GPIO, 32'h0, "gpio_before_edge");
      chk_gpio(32'h0000_00FF, "gpio_after_edge");
      rd(A_GPIO, 32'h0000_00FF, "gpio_readback");
      wr(A_CTRL, 32'hFFFF_FFFC, 4'b1111);
      rd(A_CTRL, 32'h0, "ctrl_upper_bits_zero");

      // Timer run, TIMER_DIV=4
      wr(A_CTRL, 32'h1, 4'b0001);
      idle(3);
      rd(A_MTLO, 32'd0, "div4_before_tick");
      rd(A_MTLO, 32'd1, "div4_first_tick");
      idle(15);
      rd(A_MTLO, 32'd5, "div4_after_20");
      wr(A_CTRL, 32'h0, 4'b0001);
      rd(A_MTLO, 32'd5, "div4_frozen_a");
      idle(10);
      rd(A_MTLO, 32'd5, "div4_frozen_b");

      // Carry and wrap, TIMER_DIV=1
      sel_dut = 1'b1;
      wr(A_CTRL, 32'h0, 4'b0001);
      wr(A_MTLO, 32'hFFFF_FFFF, 4'b1111);
      wr(A_MTHI, 32'h0, 4'b1111);
      wr(A_CTRL, 32'h1, 4'b0001);
      rd(A_MTLO, 32'hFFFF_FFFF, "carry_pre");
      rd(A_MTLO, 32'h0, "carry_lo");
      rd(A_MTHI, 32'h1, "carry_hi");
      wr(A_CTRL, 32'h0, 4'b0001);
      wr(A_MTLO, 32'hFFFF_FFFF, 4'b1111);
      wr(A_MTHI, 32'hFFFF_FFFF, 4'b1111);
      wr(A_CTRL, 32'h1, 4'b0001);
      rd(A_MTHI, 32'hFFFF_FFFF, "wrap_pre");
      rd(A_MTHI, 32'h0, "wrap_hi");
      rd(A_MTLO, 32'h1, "wrap_lo");

      // Write versus tick collision, TIMER_DIV=1, timer running
      wr(A_MTLO, 32'h0000_0100, 4'b1111);
      rd(A_MTLO, 32'h0000_0100, "collide_write_wins");
      rd(A_MTLO, 32'h0000_0101, "collide_next_tick");
      wr(A_MTLO, 32'h0000_AB00, 4'b0010);
      rd(A_MTLO, 32'h0000_AB02, "collide_partial_lane");
      rd(A_MTLO, 32'h0000_AB03, "collide_partial_next");
      wr(A_MTHI, 32'h0000_0005, 4'b1111);
      rd(A_MTLO, 32'h0000_AB04, "collide_hi_lo_held");
      rd(A_MTHI, 32'h0000_0005, "collide_hi_value");

      // Interrupt rise, fall and asynchronous reset
      wr(A_CTRL, 32'h0, 4'b0001);
      wr(A_CMPHI, 32'h0, 4'b1111);
      wr(A_CMPLO, 32'd10, 4'b1111);
      wr(A_MTHI, 32'h0, 4'b1111);
      wr(A_MTLO, 32'h0, 4'b1111);
      wr(A_CTRL, 32'h3, 4'b0001);
      idle(10);
      chk_irq(1'b0, "irq_compare_edge");
      chk_irq(1'b1, "irq_rise");
      apply(A_CMPLO, 1'b1, 32'h0000_1000, 4'b1111, 1'b1, K_IRQ, 32'd1, "irq_during_cmp_write");
      chk_irq(1'b1, "irq_fall_latency");
      chk_irq(1'b0, "irq_fall");
      wr(A_CMPLO, 32'd5, 4'b1111);
      idle(1);
      chk_irq(1'b1, "irq_rearmed");

      @(posedge clk); #1;
      rstn = 1'b0;
      addr = '0; wr_en = 1'b0; wr_data = '0; byte_sel = '0;
      push(K_IRQ, 32'd0, "irq_async_reset");
      chk_req = 1'b1;
      chk_gpio(32'h0, "gpio_async_reset");
      rd(A_MTLO, 32'h0, "mtime_async_reset");
      rd(A_CMPLO, 32'hFFFF_FFFF, "cmp_async_reset");
      @(posedge clk); #1; rstn = 1'b1; chk_req = 1'b0;
      wr(A_GPIO, 32'h5A5A_0000, 4'b1100);
      chk_gpio(32'h5A5A_0000, "gpio_post_reset");

      @(posedge clk); #1;
      chk_req = 1'b0;
      final_chk = 1'b1;
      @(negedge clk); #1;
      final_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
